hdmi_aux_arbiter: RTL

//   Shares the sequencer's data-island (aux) channel between NUM_SRC packet sources (ACR, audio sample, InfoFrames).

---
 rtl/hdmi_pkg.sv | 21 ++
 rtl/hdmi_rr_picker.sv | 34 +++
 rtl/hdmi_aux_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI constants, operating-mode encodings and the aux arbiter state type.
package hdmi_pkg;

  localparam int AUXPACKET = 32;
  localparam int PREAMBLE  = 8;
  localparam int GUARDBAND = 2;

  typedef enum logic [1:0] {
    OPM_CTRL   = 2'd0,
    OPM_VIDEO  = 2'd1,
    OPM_ISLAND = 2'd2,
    OPM_GUARD  = 2'd3
  } opmode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } aux_state_t;

endpackage

// File: rtl/hdmi_rr_picker.sv
// Combinational round-robin picker: first requester after last_winner (cyclic),
// with optional absolute priority for source 0.
module hdmi_rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last_winner,
  input  logic               prio_en,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // Walk from farthest to nearest so the nearest requester after last_winner is kept.
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = IW'((int'(last_winner) + i) % NUM_SRC);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
    if (prio_en && req[0]) begin
      winner = '0;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_aux_arbiter.sv
// Round-robin arbiter sharing the sequencer's data-island channel among packet sources.
// Build option HDMI_AUX_PRIORITY_EN: source 0 wins every arbitration it takes part in.
module hdmi_aux_arbiter
  import hdmi_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_end,
  input  logic                      aux_enable,
  input  logic [9:0]                aux_slot,
  output logic                      aux_request,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_grant,
  output logic [NUM_SRC-1:0]        src_advance,
  output logic [NUM_SRC-1:0]        src_done,
  output logic [NUM_SRC-1:0]        src_abort,
  output logic [DATA_W-1:0]         aux_data,
  output aux_state_t                dbg_state
);

  localparam int IW = $clog2(NUM_SRC);
`ifdef HDMI_AUX_PRIORITY_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  // Handshake: a source raises src_req and holds it until src_done or src_abort.
  // While granted, each src_advance pulse means its current slot was consumed.
  aux_state_t         state, state_nxt;
  logic [IW-1:0]      owner, owner_nxt;
  logic [IW-1:0]      last_winner, last_nxt;
  logic [NUM_SRC-1:0] owner_oh;
  logic [NUM_SRC-1:0] pick_req;
  logic [IW-1:0]      pick_last;
  logic [IW-1:0]      pick;
  logic               pick_valid;
  logic               busy;
  logic               slot_last;
  logic               slot_penult;
  logic               others_pending;
  logic               unused_slot_hi;

  assign unused_slot_hi = ^aux_slot[9:5];
  assign busy           = (state != IDLE);
  assign owner_oh       = busy ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << owner) : '0;
  assign slot_last      = (aux_slot[4:0] == 5'(AUXPACKET - 1));
  assign slot_penult    = (aux_slot[4:0] == 5'(AUXPACKET - 2));
  assign others_pending = |(src_req & ~owner_oh);
  assign dbg_state      = state;

  // On completion the just-finished owner becomes the rotation origin and is excluded.
  assign pick_req  = (state == IDLE) ? src_req : (src_req & ~owner_oh);
  assign pick_last = (state == SEND) ? owner : last_winner;

  hdmi_rr_picker #(.NUM_SRC(NUM_SRC), .IW(IW)) u_picker (
    .req         (pick_req),
    .last_winner (pick_last),
    .prio_en     (PRIO_EN),
    .winner      (pick),
    .valid       (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_winner <= IW'(NUM_SRC - 1);
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_winner <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_winner;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (aux_enable) state_nxt = SEND;
      end
      SEND: begin
        if (aux_enable && slot_last) begin
          last_nxt = owner;
          if (pick_valid) begin
            owner_nxt = pick;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // frame_end overrides everything, including a same-cycle completion.
    if (frame_end) begin
      state_nxt = IDLE;
      owner_nxt = owner;
      last_nxt  = last_winner;
    end
  end

  always_comb begin
    src_grant   = owner_oh;
    src_advance = (aux_enable && busy) ? owner_oh : '0;
    src_done    = (state == SEND && aux_enable && slot_last && !frame_end) ? owner_oh : '0;
    src_abort   = frame_end ? owner_oh : '0;
    aux_data    = (aux_enable && busy) ? src_data[int'(owner)*DATA_W +: DATA_W] : '0;
    unique case (state)
      WAIT:    aux_request = 1'b1;
      SEND:    aux_request = !(slot_penult && aux_enable && !others_pending);
      default: aux_request = 1'b0;
    endcase
  end

endmodule
